nibble_serializer: RTL and testbench

Parallel-in, serial-out companion to the team's 4-stage nibble shift register: accepts one DEPTH-element word in a single handshake and emits it one WIDTH-bit element per beat over a valid/ready stream. Elements leave in the order the shift register expects. Element 0 is emitted first, so after DEPTH enabled cycles the receiving chain holds element 0 in its last stage and element DEPTH-1 in its first. The block sits on the transmit side of the nibble link, between a word-wide producer and the serial chain.

---
 rtl/nibble_pkg.sv | 14 +
 rtl/nibble_serializer.sv | 82 ++++++++
 tb/tb_nibble_serializer.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/nibble_pkg.sv
// Shared definitions for the nibble link: element/word geometry and
// serializer FSM states.
package nibble_pkg;

  localparam int unsigned NIB_WIDTH = 4;
  localparam int unsigned NIB_DEPTH = 4;
  localparam int unsigned NIB_CNT_W = $clog2(NIB_DEPTH);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

endpackage

// File: rtl/nibble_serializer.sv
// Parallel-in, serial-out word serializer: captures DEPTH elements in one
// handshake and streams them element 0 first over valid/ready.
module nibble_serializer
  import nibble_pkg::*;
#(
  parameter int unsigned WIDTH = NIB_WIDTH,
  parameter int unsigned DEPTH = NIB_DEPTH
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   load_valid,
  output logic                   load_ready,
  input  logic [DEPTH*WIDTH-1:0] load_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH-1:0]       out_data,
  output logic                   out_last,
  output logic                   busy
);

  localparam int unsigned CNT_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DEPTH - 1);

  state_e                        state_q, state_d;
  logic [DEPTH-1:0][WIDTH-1:0]   stage_q, stage_d;
  logic [CNT_W-1:0]              count_q, count_d;

  // Next-state: load from IDLE, shift on each beat, reload on the last beat
  // when a producer is waiting so words follow with no bubble.
  always_comb begin
    state_d = state_q;
    stage_d = stage_q;
    count_d = count_q;
    case (state_q)
      IDLE: begin
        if (load_valid) begin
          stage_d = load_data;
          count_d = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (out_ready) begin
          if (count_q == LAST_CNT) begin
            count_d = '0;
            if (load_valid) begin
              stage_d = load_data;
            end else begin
              stage_d = stage_q >> WIDTH;
              state_d = IDLE;
            end
          end else begin
            stage_d = stage_q >> WIDTH;
            count_d = count_q + CNT_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      stage_q <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      stage_q <= stage_d;
      count_q <= count_d;
    end
  end

  // Outputs come straight off the state/stage/count flops; only load_ready
  // also sees out_ready, to allow the same-cycle handoff.
  assign out_valid  = (state_q == SHIFT);
  assign busy       = (state_q == SHIFT);
  assign out_data   = stage_q[0];
  assign out_last   = (state_q == SHIFT) && (count_q == LAST_CNT);
  assign load_ready = (state_q == IDLE) || (out_last && out_ready);

endmodule

// File: tb/tb_nibble_serializer.sv
// Directed bench for nibble_serializer, including a 4-stage receive chain
// fed by the serial stream.
module tb_nibble_serializer;
  import nibble_pkg::*;

  localparam int unsigned W = NIB_WIDTH;
  localparam int unsigned D = NIB_DEPTH;

  logic           clk = 1'b0;
  logic           reset;
  logic           load_valid;
  logic           load_ready;
  logic [D*W-1:0] load_data;
  logic           out_valid;
  logic           out_ready;
  logic [W-1:0]   out_data;
  logic           out_last;
  logic           busy;

  logic [W-1:0]   dout0, dout1, dout2, dout3;

  int n_checks = 0;
  int n_fail   = 0;

  nibble_serializer #(.WIDTH(W), .DEPTH(D)) dut (
    .clk        (clk),
    .reset      (reset),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_data  (load_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_last   (out_last),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Receiving shift register: element enters dout0 and moves toward dout3.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      {dout3, dout2, dout1, dout0} <= '0;
    end else if (out_valid && out_ready) begin
      {dout3, dout2, dout1, dout0} <= {dout2, dout1, dout0, out_data};
    end
  end

  // {out_valid, out_last, load_ready, busy, out_data}
  function automatic logic [7:0] status();
    return {out_valid, out_last, load_ready, busy, out_data};
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [7:0] exp;
    reset = 1'b1; load_valid = 1'b1; load_data = 16'h4321; out_ready = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      next_cycle(); #1;
      n_checks++;
      if (status() !== 8'b0010_0000) begin
        n_fail++;
        $display("FAIL reset_hold cyc%0d: got %b expected 00100000", i, status());
      end
    end
    next_cycle();
    reset = 1'b0;
    #1;
    n_checks++;
    if (status() !== 8'b0010_0000) begin
      n_fail++;
      $display("FAIL reset_release_idle: got %b expected 00100000", status());
    end
    for (int i = 0; i < 4; i++) begin
      next_cycle();
      load_valid = 1'b0;
      #1;
      exp = {1'b1, (i == 3), (i == 3), 1'b1, 4'(i + 1)};
      n_checks++;
      if (status() !== exp) begin
        n_fail++;
        $display("FAIL reset_stream beat%0d: got %b expected %b", i, status(), exp);
      end
    end
    next_cycle(); #1;
    n_checks++;
    if (status() !== 8'b0010_0000) begin
      n_fail++;
      $display("FAIL reset_word_idle: got %b expected 00100000", status());
    end
  endtask

  task automatic test_round_trip();
    load_valid = 1'b1; load_data = 16'hDCBA; out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      next_cycle();
      load_valid = 1'b0;
    end
    #1;
    n_checks++;
    if ({dout3, dout2, dout1, dout0} !== 16'hABCD) begin
      n_fail++;
      $display("FAIL round_trip_chain: got %h expected abcd", {dout3, dout2, dout1, dout0});
    end
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL round_trip_idle: got out_valid %b expected 0", out_valid);
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] exp;
    load_valid = 1'b1; load_data = 16'h8765; out_ready = 1'b1;
    next_cycle();
    load_valid = 1'b0;
    #1;
    n_checks++;
    if (status() !== 8'b1001_0101) begin
      n_fail++;
      $display("FAIL bp_first: got %b expected 10010101", status());
    end
    next_cycle();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_checks++;
      if (status() !== 8'b1001_0110) begin
        n_fail++;
        $display("FAIL bp_stall cyc%0d: got %b expected 10010110", i, status());
      end
      next_cycle();
    end
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      exp = {1'b1, (i == 2), (i == 2), 1'b1, 4'(i + 6)};
      n_checks++;
      if (status() !== exp) begin
        n_fail++;
        $display("FAIL bp_release beat%0d: got %b expected %b", i, status(), exp);
      end
      next_cycle();
    end
    #1;
    n_checks++;
    if (status() !== 8'b0010_0000) begin
      n_fail++;
      $display("FAIL bp_idle: got %b expected 00100000", status());
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp;
    load_valid = 1'b1; load_data = 16'h4321; out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      next_cycle();
      load_valid = (i == 3);
      load_data  = (i == 3) ? 16'h8765 : 16'h0000;
      #1;
      exp = {1'b1, (i == 3 || i == 7), (i == 3 || i == 7), 1'b1, 4'(i + 1)};
      n_checks++;
      if (status() !== exp) begin
        n_fail++;
        $display("FAIL b2b beat%0d: got %b expected %b", i, status(), exp);
      end
    end
    load_valid = 1'b0;
    next_cycle(); #1;
    n_checks++;
    if (status() !== 8'b0010_0000) begin
      n_fail++;
      $display("FAIL b2b_idle: got %b expected 00100000", status());
    end
  endtask

  task automatic test_mid_reset();
    logic [7:0] exp;
    load_valid = 1'b1; load_data = 16'h4321; out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      next_cycle();
      load_valid = 1'b0;
      #1;
      exp = {1'b1, 1'b0, 1'b0, 1'b1, 4'(i + 1)};
      n_checks++;
      if (status() !== exp) begin
        n_fail++;
        $display("FAIL midrst_pre beat%0d: got %b expected %b", i, status(), exp);
      end
    end
    next_cycle();
    reset = 1'b1;
    #1;
    n_checks++;
    if (status() !== 8'b0010_0000) begin
      n_fail++;
      $display("FAIL midrst_drop: got %b expected 00100000", status());
    end
    next_cycle();
    reset = 1'b0; load_valid = 1'b1; load_data = 16'hFEDC;
    for (int i = 0; i < 4; i++) begin
      next_cycle();
      load_valid = 1'b0;
      #1;
      exp = {1'b1, (i == 3), (i == 3), 1'b1, 4'(i + 12)};
      n_checks++;
      if (status() !== exp) begin
        n_fail++;
        $display("FAIL midrst_post beat%0d: got %b expected %b", i, status(), exp);
      end
    end
    next_cycle(); #1;
    n_checks++;
    if (status() !== 8'b0010_0000) begin
      n_fail++;
      $display("FAIL midrst_idle: got %b expected 00100000", status());
    end
  endtask

  task automatic test_ignored_load();
    logic [7:0] exp;
    load_valid = 1'b1; load_data = 16'h4321; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      next_cycle();
      load_valid = (i == 1 || i == 2);
      load_data  = 16'hAAAA;
      #1;
      exp = {1'b1, (i == 3), (i == 3), 1'b1, 4'(i + 1)};
      n_checks++;
      if (status() !== exp) begin
        n_fail++;
        $display("FAIL ignored beat%0d: got %b expected %b", i, status(), exp);
      end
    end
    next_cycle(); #1;
    n_checks++;
    if (status() !== 8'b0010_0000) begin
      n_fail++;
      $display("FAIL ignored_idle: got %b expected 00100000", status());
    end
  endtask

  initial begin
    test_reset();
    test_round_trip();
    test_backpressure();
    test_back_to_back();
    test_mid_reset();
    test_ignored_load();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
